bank_register_mp: RTL

BANK_REGISTER_MP -- requirements
Module: bank_register_mp

---
 rtl/bank_register_mp.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bank_register_mp.sv
// Register bank with NUM_RD registered read ports, write bypass,
// a soft-clear sweep and a side-band debug read port.
module bank_register_mp #(
    parameter int DATA_SIZE = 32,
    parameter int REG_SIZE  = 5,
    parameter int BANK_SIZE = 32,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic                         i_enable,
    input  logic                         i_clear,
    input  logic                         i_reg_write,
    input  logic [REG_SIZE-1:0]          i_write_reg,
    input  logic [DATA_SIZE-1:0]         i_write_data,
    input  logic [NUM_RD*REG_SIZE-1:0]   i_read_regs,
    output logic [NUM_RD*DATA_SIZE-1:0]  o_data,
    output logic                         o_ready,
    input  logic                         i_dbg_req,
    input  logic [REG_SIZE-1:0]          i_dbg_addr,
    output logic [DATA_SIZE-1:0]         o_dbg_data,
    output logic                         o_dbg_valid
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [REG_SIZE-1:0] LAST_IDX = REG_SIZE'(BANK_SIZE - 1);

    state_t                state;
    logic [REG_SIZE-1:0]   clr_idx;
    logic                  ready_q;
    logic [DATA_SIZE-1:0]  regs    [BANK_SIZE];
    logic [DATA_SIZE-1:0]  data_q  [NUM_RD];
    logic [DATA_SIZE-1:0]  rd_next [NUM_RD];
    logic [DATA_SIZE-1:0]  dbg_q;
    logic                  dbg_v_q;
    logic                  run;
    logic                  wr_en;

    // Address backed by real storage (not the hardwired zero register).
    function automatic logic addr_live(input logic [REG_SIZE-1:0] a);
        return (32'(a) < BANK_SIZE) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [DATA_SIZE-1:0] peek(input logic [REG_SIZE-1:0] a);
        return addr_live(a) ? regs[a] : '0;
    endfunction

    assign run   = (state == ST_RUN);
    assign wr_en = run && i_enable && i_reg_write && addr_live(i_write_reg);

    // Clear sweep / run sequencing; o_ready tracks the state register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    if (i_clear) begin
                        clr_idx <= '0;
                    end else if (clr_idx == LAST_IDX) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_clear) begin
                        state   <= ST_CLEAR;
                        ready_q <= 1'b0;
                        clr_idx <= '0;
                    end
                end
            endcase
        end
    end

    // Storage: the sweep zeroes one entry per cycle, otherwise normal writes.
    always_ff @(posedge i_clock) begin
        if (!run) begin
            regs[clr_idx] <= '0;
        end else if (wr_en) begin
            regs[i_write_reg] <= i_write_data;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [REG_SIZE-1:0] addr;
        assign addr       = i_read_regs[k*REG_SIZE +: REG_SIZE];
        assign rd_next[k] = (wr_en && (addr == i_write_reg))
                          ? i_write_data : peek(addr);
        assign o_data[k*DATA_SIZE +: DATA_SIZE] = data_q[k];
    end

    // Read ports advance only when running and enabled.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NUM_RD; k++) begin
                data_q[k] <= '0;
            end
        end else if (run && i_enable) begin
            data_q <= rd_next;
        end
    end

    // Debug read sees the pre-write contents and ignores i_enable.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            dbg_q   <= '0;
            dbg_v_q <= 1'b0;
        end else begin
            dbg_v_q <= run && i_dbg_req;
            if (run && i_dbg_req) begin
                dbg_q <= peek(i_dbg_addr);
            end
        end
    end

    assign o_ready     = ready_q;
    assign o_dbg_data  = dbg_q;
    assign o_dbg_valid = dbg_v_q;

endmodule
